cart_mbc: RTL and testbench

Parametrised MBC1-style cartridge mapper between the gameboy external bus (A/Do/Di/wr_n/rd_n/cs_n) and cartridge ROM/RAM backing stores. Replaces the flat 32 KiB `A[14]` ROM/WRAM decode with bank-switched ROM (up to 2 MiB) and enable-gated, bank-switched external RAM. It holds the mapper control registers, generates backing-store addresses, and returns read data on Di. It sits in the board top, beside the WRAM/VRAM `async_mem` instances.

---
 rtl/cart_mbc.sv | 108 ++++++++++
 tb/tb_cart_mbc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_mbc.sv
// MBC1-style cartridge mapper: bank-switched ROM, enable-gated bank-switched RAM, bus read mux.
// Define MBC_BANK_MODE_EN to implement the banking-mode register; otherwise mode is fixed at 0.
module cart_mbc #(
    parameter int ROM_BANKS = 64,
    parameter int RAM_BANKS = 4,
    localparam int ROM_AW = $clog2(ROM_BANKS) + 14,
    localparam int RAM_AW = $clog2(RAM_BANKS) + 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       A,
    input  logic [7:0]        Do,
    output logic [7:0]        Di,
    input  logic              wr_n,
    input  logic              rd_n,
    input  logic              cs_n,
    output logic              hit,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic [6:0]        rom_bank,
    output logic [1:0]        ram_bank,
    output logic              ram_en
);

    localparam logic [6:0] ROM_MASK = 7'(ROM_BANKS - 1);
    localparam logic [1:0] RAM_MASK = 2'(RAM_BANKS - 1);

    logic       ram_en_r;
    logic [4:0] bank_lo;
    logic [1:0] bank_hi;
    logic       mode;
    logic       wr_q;
    logic       wr_act;
    logic       wr_pulse;
    logic       in_rom;
    logic       in_ram;
    logic [6:0] bank_r0;
    logic [6:0] bank_r1;
    logic [6:0] bank_sel;

    assign wr_act   = !cs_n && !wr_n;
    assign wr_pulse = wr_act && !wr_q;
    assign in_rom   = !A[15];
    assign in_ram   = (A[15:13] == 3'b101);

    // Registers change only on the leading cycle of a write, so a long strobe commits once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q     <= 1'b0;
            ram_en_r <= 1'b0;
            bank_lo  <= 5'd1;
            bank_hi  <= 2'd0;
        end else begin
            wr_q <= wr_act;
            if (wr_pulse) begin
                case (A[15:13])
                    3'b000:  ram_en_r <= (Do[3:0] == 4'hA);
                    3'b001:  bank_lo  <= (Do[4:0] == 5'd0) ? 5'd1 : Do[4:0];
                    3'b010:  bank_hi  <= Do[1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef MBC_BANK_MODE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode <= 1'b0;
        end else if (wr_pulse && A[15:13] == 3'b011) begin
            mode <= Do[0];
        end
    end
`else
    assign mode = 1'b0;
`endif

    // Out-of-range banks wrap by masking to the populated bank count.
    assign bank_r1  = {bank_hi, bank_lo} & ROM_MASK;
    assign bank_r0  = (mode ? {bank_hi, 5'b0} : 7'd0) & ROM_MASK;
    assign bank_sel = A[14] ? bank_r1 : bank_r0;
    assign rom_addr = ROM_AW'({bank_sel, A[13:0]});
    assign rom_bank = bank_r1;

    assign ram_bank  = (mode ? bank_hi : 2'd0) & RAM_MASK;
    assign ram_addr  = RAM_AW'({ram_bank, A[12:0]});
    assign ram_wdata = Do;
    assign ram_we    = wr_pulse && in_ram && ram_en_r;
    assign ram_en    = ram_en_r;

    assign hit = !cs_n && !rd_n && (in_rom || in_ram);

    always_comb begin
        Di = 8'hFF;
        if (hit) begin
            if (in_rom) begin
                Di = rom_data;
            end else if (ram_en_r) begin
                Di = ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cart_mbc.sv
// Testbench for cart_mbc: directed and random bus traffic checked against a behavioural mapper model.
module tb_cart_mbc;

    localparam int ROM_BANKS = 64;
    localparam int RAM_BANKS = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [7:0]  Do = 8'h00;
    logic        wr_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        cs_n = 1'b1;
    logic [7:0]  Di;
    logic        hit;
    logic [19:0] rom_addr;
    logic [7:0]  rom_data;
    logic [14:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic [6:0]  rom_bank;
    logic [1:0]  ram_bank;
    logic        ram_en;

    logic [7:0]  di8;
    logic        hit8;
    logic [16:0] rom_addr8;
    logic [14:0] ram_addr8;
    logic [7:0]  ram_wdata8;
    logic        ram_we8;
    logic [6:0]  rom_bank8;
    logic [1:0]  ram_bank8;
    logic        ram_en8;

    int n_checks = 0;
    int n_errors = 0;

    int m_ram_en, m_lo, m_hi, m_mode;

    always #5 clock = ~clock;

    // Backing stores return a data pattern derived from the address they are given.
    assign rom_data  = rom_addr[7:0] ^ {2'b00, rom_addr[19:14]};
    assign ram_rdata = ram_addr[7:0] ^ {6'b0, ram_addr[14:13]} ^ 8'h5A;

    cart_mbc #(.ROM_BANKS(ROM_BANKS), .RAM_BANKS(RAM_BANKS)) dut (
        .clock(clock), .reset(reset), .A(A), .Do(Do), .Di(Di),
        .wr_n(wr_n), .rd_n(rd_n), .cs_n(cs_n), .hit(hit),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .rom_bank(rom_bank), .ram_bank(ram_bank), .ram_en(ram_en)
    );

    cart_mbc #(.ROM_BANKS(8), .RAM_BANKS(RAM_BANKS)) dut8 (
        .clock(clock), .reset(reset), .A(A), .Do(Do), .Di(di8),
        .wr_n(wr_n), .rd_n(rd_n), .cs_n(cs_n), .hit(hit8),
        .rom_addr(rom_addr8), .rom_data(8'h00),
        .ram_addr(ram_addr8), .ram_wdata(ram_wdata8), .ram_we(ram_we8), .ram_rdata(8'h00),
        .rom_bank(rom_bank8), .ram_bank(ram_bank8), .ram_en(ram_en8)
    );

    function automatic void model_reset();
        m_ram_en = 0; m_lo = 1; m_hi = 0; m_mode = 0;
    endfunction

    function automatic void model_write(int addr, int data);
        if (addr < 'h2000) m_ram_en = ((data % 16) == 10) ? 1 : 0;
        else if (addr < 'h4000) m_lo = ((data % 32) == 0) ? 1 : data % 32;
        else if (addr < 'h6000) m_hi = data % 4;
`ifdef MBC_BANK_MODE_EN
        else if (addr < 'h8000) m_mode = data % 2;
`endif
    endfunction

    function automatic int exp_rom_bank(int banks);
        return (m_hi * 32 + m_lo) % banks;
    endfunction

    function automatic int exp_rom_addr(int addr);
        int bank;
        if (addr >= 'h4000) bank = exp_rom_bank(ROM_BANKS);
        else bank = m_mode ? (m_hi * 32) % ROM_BANKS : 0;
        return bank * 16384 + addr % 16384;
    endfunction

    function automatic int exp_ram_bank();
        return m_mode ? m_hi % RAM_BANKS : 0;
    endfunction

    function automatic int exp_ram_addr(int addr);
        return exp_ram_bank() * 8192 + addr % 8192;
    endfunction

    function automatic int exp_di(int addr);
        int ra;
        if (addr < 'h8000) begin
            ra = exp_rom_addr(addr);
            return (ra % 256) ^ ((ra / 16384) % 64);
        end
        if (addr >= 'hA000 && addr < 'hC000) begin
            if (m_ram_en == 0) return 'hFF;
            ra = exp_ram_addr(addr);
            return (ra % 256) ^ ((ra / 8192) % 4) ^ 'h5A;
        end
        return 'hFF;
    endfunction

    function automatic bit in_ram_region(int addr);
        return addr >= 'hA000 && addr < 'hC000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        checkOutput("rom_bank", 32'(rom_bank), 32'(exp_rom_bank(ROM_BANKS)));
        checkOutput("rom_bank8", 32'(rom_bank8), 32'(exp_rom_bank(8)));
        checkOutput("ram_bank", 32'(ram_bank), 32'(exp_ram_bank()));
        checkOutput("ram_en", 32'(ram_en), 32'(m_ram_en));
    endtask

    task automatic do_read(input int addr);
        @(negedge clock);
        A = 16'(addr); cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
        #1;
        checkOutput("read_di", 32'(Di), 32'(exp_di(addr)));
        checkOutput("read_hit", 32'(hit), 32'((addr < 'h8000 || in_ram_region(addr)) ? 1 : 0));
        if (addr < 'h8000) checkOutput("read_rom_addr", 32'(rom_addr), 32'(exp_rom_addr(addr)));
        if (in_ram_region(addr)) checkOutput("read_ram_addr", 32'(ram_addr), 32'(exp_ram_addr(addr)));
        check_state();
        #1;
        cs_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic applyStimulus(input int addr, input int data, input int hold, input bit with_rd);
        int wes;
        wes = 0;
        @(negedge clock);
        A = 16'(addr); Do = 8'(data); cs_n = 1'b0; wr_n = 1'b0; rd_n = with_rd ? 1'b0 : 1'b1;
        for (int i = 0; i < hold; i++) begin
            #1;
            if (ram_we) begin
                wes++;
                checkOutput("we_ram_addr", 32'(ram_addr), 32'(exp_ram_addr(addr)));
                checkOutput("we_ram_wdata", 32'(ram_wdata), 32'(data));
            end
            if (i == 0 && with_rd) checkOutput("rdwr_di", 32'(Di), 32'(exp_di(addr)));
            @(negedge clock);
        end
        wr_n = 1'b1; cs_n = 1'b1; rd_n = 1'b1;
        checkOutput("ram_we_count", 32'(wes), 32'((in_ram_region(addr) && m_ram_en != 0) ? 1 : 0));
        model_write(addr, data);
    endtask

    initial begin
        int addr, data;
        model_reset();

        repeat (2) @(negedge clock);
        #1;
        checkOutput("rst_rom_bank", 32'(rom_bank), 32'd1);
        checkOutput("rst_ram_bank", 32'(ram_bank), 32'd0);
        checkOutput("rst_ram_en", 32'(ram_en), 32'd0);
        checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
        checkOutput("rst_di", 32'(Di), 32'hFF);
        checkOutput("rst_hit", 32'(hit), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        do_read('h4000);
        checkOutput("rom_addr_4000", 32'(rom_addr), 32'h04000);
        do_read('h9000);

        applyStimulus('h2100, 'h00, 1, 1'b0);
        do_read('h4000);
        applyStimulus('h2100, 'h05, 1, 1'b0);
        do_read('h4000);
        checkOutput("rom_addr_bank5", 32'(rom_addr), 32'h14000);

        applyStimulus('h0000, 'h0A, 1, 1'b0);
        applyStimulus('hA010, 'h42, 4, 1'b0);
        do_read('hA010);
        applyStimulus('h0000, 'h00, 1, 1'b0);
        do_read('hA010);
        checkOutput("ram_off_di", 32'(Di), 32'hFF);
        applyStimulus('hA010, 'h99, 2, 1'b0);

        applyStimulus('h2000, 'h1F, 1, 1'b0);
        do_read('h4000);
        checkOutput("rom_bank8_mask", 32'(rom_bank8), 32'd7);
        applyStimulus('h4000, 'h01, 1, 1'b0);
        do_read('h4000);

        applyStimulus('h6000, 'h01, 1, 1'b0);
        applyStimulus('h4000, 'h02, 1, 1'b0);
        do_read('h0000);
        do_read('h7FFF);
        applyStimulus('h0000, 'h0A, 1, 1'b0);
        do_read('hA000);
        do_read('hBFFF);
        do_read('hC000);
        applyStimulus('hA055, 'h77, 2, 1'b1);

        // Reset lands while a register write strobe is held low, then releases under it.
        @(negedge clock);
        A = 16'h2000; Do = 8'h03; cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
        #2 reset = 1'b0;
        #1;
        model_reset();
        checkOutput("midrst_ram_en", 32'(ram_en), 32'd0);
        checkOutput("midrst_rom_bank", 32'(rom_bank), 32'd1);
        checkOutput("midrst_ram_bank", 32'(ram_bank), 32'd0);
        checkOutput("midrst_ram_we", 32'(ram_we), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        wr_n = 1'b1; cs_n = 1'b1;
        model_write('h2000, 'h03);
        do_read('h4000);
        checkOutput("postrst_rom_bank", 32'(rom_bank), 32'd3);

        for (int n = 0; n < 300; n++) begin
            addr = int'($urandom_range(0, 15)) * 4096 + int'($urandom_range(0, 4095));
            if ($urandom_range(0, 2) == 0) begin
                do_read(addr);
            end else begin
                data = int'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) data = (data & 'hF0) | 'h0A;
                applyStimulus(addr, data, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
